// File: rtl/booth_radix4_seq_mult.sv
// Sequential radix-4 Booth multiplier: one Booth digit retired per clock
// through a single shared adder. Operands are captured on accept, the
// product is registered on entry to DONE and held until the next DONE entry.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. in_ready is high only in IDLE, out_valid only in DONE; abort
// overrides both transfers in the cycle it is sampled.
module booth_radix4_seq_mult #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               abort,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_signed,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_p,
   output logic               busy,
   output logic [1:0]         dbg_state
);

   localparam int ITER = (WIDTH + 2) / 2;   // Booth digits per operation
   localparam int XW   = WIDTH + 2;         // extended operand width
   localparam int AW   = 2 * WIDTH + 4;     // accumulator width
   localparam int CW   = $clog2(ITER);      // digit counter width

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [AW-1:0]      acc_q, acc_d;     // running sum of digit*A terms
   logic [AW-1:0]      mcand_q, mcand_d; // A, pre-shifted left 2 per digit
   logic [XW-1:0]      mplier_q, mplier_d; // B, shifted right 2 per digit
   logic               prev_q, prev_d;   // Bx[2i-1] for the current digit
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;

   logic [XW-1:0]      a_x, b_x;
   logic [2:0]         digit;
   logic [AW-1:0]      term;
   logic [AW-1:0]      sum;

   // Operand extension, digit decode and the single shared adder
   always_comb begin
      a_x   = in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
      b_x   = in_signed ? {{2{in_b[WIDTH-1]}}, in_b} : {2'b00, in_b};
      digit = {mplier_q[1], mplier_q[0], prev_q};
      case (digit)
         3'b001, 3'b010: term = mcand_q;
         3'b011:         term = mcand_q << 1;
         3'b100:         term = -(mcand_q << 1);
         3'b101, 3'b110: term = -mcand_q;
         default:        term = '0;
      endcase
      sum = acc_q + term;
   end

   // Next-state and datapath update; abort wins over every handshake
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      prev_d   = prev_q;
      cnt_d    = cnt_q;
      prod_d   = prod_q;
      if (abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  state_d  = S_RUN;
                  acc_d    = '0;
                  mcand_d  = {{(AW-XW){a_x[XW-1]}}, a_x};
                  mplier_d = b_x;
                  prev_d   = 1'b0;
                  cnt_d    = '0;
               end
            end
            S_RUN: begin
               acc_d    = sum;
               mcand_d  = mcand_q << 2;
               mplier_d = mplier_q >> 2;
               prev_d   = mplier_q[1];
               cnt_d    = cnt_q + CW'(1);
               if (cnt_q == CW'(ITER - 1)) begin
                  state_d = S_DONE;
                  cnt_d   = '0;
                  prod_d  = sum[2*WIDTH-1:0];
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers, asynchronously cleared
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         prev_q   <= 1'b0;
         cnt_q    <= '0;
         prod_q   <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         prev_q   <= prev_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign busy      = (state_q != S_IDLE);
   assign out_p     = prod_q;
   assign dbg_state = state_q;

endmodule

// File: doc/booth_radix4_seq_mult.md
Name: booth_radix4_seq_mult

Overview:
- Multi-cycle, parametrised radix-4 Booth multiplier. Retires one Booth digit per clock.
- Supports signed or unsigned operands, selected per operation.
- Uses a valid/ready handshake on both input and output.
- Successor to the single-cycle 32-bit combinational Booth unit. Replaces its 16-row adder array with one shared adder, for area-constrained datapaths that tolerate fixed multi-cycle latency.

Parameters:
- WIDTH, 32, operand width in bits; must be even and >= 4.
- ITER, (WIDTH+2)/2, Booth digits per operation; derived, not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- abort  in  1  synchronous cancel of any in-flight or pending operation
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- in_signed  in  1  1 = two's-complement operands, 0 = unsigned
- in_a  in  WIDTH  multiplicand
- in_b  in  WIDTH  multiplier
- out_valid  out  1  product valid
- out_ready  in  1  consumer accepts product
- out_p  out  2*WIDTH  product, held stable while out_valid=1
- busy  out  1  high in RUN or DONE

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, out_p=0, digit counter=0, accumulator=0.
- States:
  - IDLE: in_ready=1. When in_valid=1, capture the operands and go to RUN with counter=0.
  - RUN: one digit per cycle. When counter reaches ITER-1, go to DONE.
  - DONE: out_valid=1. When out_ready=1, go to IDLE.
- Operand extension at capture:
  - in_signed=1: sign-extend A and B to WIDTH+2 bits.
  - in_signed=0: zero-extend A and B to WIDTH+2 bits.
  - Because of this extension, an unsigned full-scale operand is never misread as negative.
- Booth digit i (0..ITER-1): bits {Bx[2i+1], Bx[2i], Bx[2i-1]}, with Bx[-1]=0.
  - 000, 111 -> 0
  - 001, 010 -> +A
  - 011 -> +2A
  - 100 -> -2A
  - 101, 110 -> -A
- Datapath:
  - The accumulator is at least 2*WIDTH+4 bits.
  - Each RUN cycle adds digit*A shifted left by 2i. A shift-register implementation (accumulator shifted right 2 per cycle) is equally valid.
  - Results must be bit-exact to the true product modulo 2^(2*WIDTH).
  - Negation is two's complement on the full accumulator width.
- Output: out_p is the low 2*WIDTH bits of the final accumulator. It is registered on entry to DONE and is unchanged until the next DONE entry.
- Latency: operands accepted at edge k -> out_valid=1 after edge k+ITER (ITER RUN cycles). Default WIDTH=32 gives 17 cycles.
- Throughput: one operation per ITER+2 cycles when out_ready is held high. in_ready=0 in RUN and DONE; there is no overlap.
- Output backpressure: out_valid stays 1 indefinitely while out_ready=0, and out_p is held.
- abort:
  - In any state, abort=1 at an edge forces IDLE, out_valid=0, counter=0; out_p retains its last value.
  - abort takes priority over in_valid and over out_ready in the same cycle.
  - An operation offered with in_valid=1 in an abort cycle is not accepted.
- Mid-operation reset: asynchronous return to reset values. No partial product is ever presented.
- Changes on in_a, in_b or in_signed after capture have no effect.
- Simultaneous out_valid & out_ready & in_valid: the product retires, the block goes to IDLE, and new operands are accepted on the next cycle.

Test Plan:
- WIDTH=32, signed, A=-7, B=3 -> out_p=0xFFFFFFFFFFFFFFEB; out_valid rises exactly 17 cycles after the accept edge.
- Unsigned, A=B=0xFFFFFFFF -> out_p=0xFFFFFFFE00000001. Same bits with in_signed=1 -> out_p=0x0000000000000001.
- Signed, A=B=0x80000000 -> out_p=0x4000000000000000. Signed A=0x80000000, B=0x7FFFFFFF -> 0xC000000080000000.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_p and out_valid stable, in_ready=0. Then pulse out_ready -> IDLE next cycle with in_ready=1.
- abort at RUN counter=5 -> IDLE next edge, out_valid never asserts. Next op A=12345, B=-678 unsigned=0 -> out_p=-8369910 sign-extended.
- rst_n low mid-RUN, then a random regression of 10k operations with WIDTH in {8, 16, 32} and mixed modes -> all outputs at reset values; every product matches the reference model.
